// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Purpose  : 4x4 keypad column scanner, press/release debouncer and encoder.
//            Optional auto-repeat is enabled with macro KEYPAD_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CYC = 8,
  parameter int REPEAT_CYC   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keyPadInput,
  output logic [3:0] keyPadOutput,
  output logic [3:0] keyCode,
  output logic       keyValid,
  output logic       keyHeld
);

  localparam int c_MAXP = (SCAN_DIV > DEBOUNCE_CYC) ?
                          ((SCAN_DIV > REPEAT_CYC) ? SCAN_DIV : REPEAT_CYC) :
                          ((DEBOUNCE_CYC > REPEAT_CYC) ? DEBOUNCE_CYC : REPEAT_CYC);
  localparam int CW = $clog2(c_MAXP) + 1;

  localparam logic [CW-1:0] c_SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] c_DEB       = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] c_REL_LAST  = CW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_col, w_col_nxt;
  logic [3:0]      r_drv;
  logic [CW-1:0]   r_slot, w_slot_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]      r_cand_row, w_cand_row_nxt;
  logic [3:0]      r_cand_pat, w_cand_pat_nxt;
  logic [3:0]      r_key_code, w_code_nxt;
  logic            r_key_valid, w_valid_nxt;
  logic            r_key_held, w_held_nxt;
  logic            w_one_low;
  logic [1:0]      w_row_idx;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CW-1:0] c_REP_LAST = CW'(REPEAT_CYC - 1);
  logic [CW-1:0]   r_rep, w_rep_nxt;
`endif

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b1000;
    return ~(one >> c);
  endfunction

  // Exactly one row low identifies a candidate key; anything else is ignored.
  always_comb begin
    w_one_low = 1'b1;
    w_row_idx = 2'd0;
    case (keyPadInput)
      4'b0111: w_row_idx = 2'd0;
      4'b1011: w_row_idx = 2'd1;
      4'b1101: w_row_idx = 2'd2;
      4'b1110: w_row_idx = 2'd3;
      default: w_one_low = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_col_nxt      = r_col;
    w_slot_nxt     = r_slot;
    w_cnt_nxt      = r_cnt;
    w_cand_row_nxt = r_cand_row;
    w_cand_pat_nxt = r_cand_pat;
    w_code_nxt     = r_key_code;
    w_valid_nxt    = 1'b0;
    w_held_nxt     = r_key_held;
`ifdef KEYPAD_REPEAT_EN
    w_rep_nxt      = r_rep;
`endif
    case (r_state)
      S_SCAN: begin
        if (r_slot == c_SLOT_LAST) begin
          w_slot_nxt = '0;
          if (w_one_low) begin
            w_cand_row_nxt = w_row_idx;
            w_cand_pat_nxt = keyPadInput;
            // The sample cycle itself is the first stable cycle.
            w_cnt_nxt      = CW'(1);
            w_state_nxt    = S_DEBOUNCE;
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end else begin
          w_slot_nxt = r_slot + CW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (keyPadInput != r_cand_pat) begin
          w_state_nxt = S_SCAN;
          w_slot_nxt  = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DEB) begin
          w_code_nxt  = {r_col, r_cand_row};
          w_valid_nxt = 1'b1;
          w_held_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_HELD;
`ifdef KEYPAD_REPEAT_EN
          w_rep_nxt   = '0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_HELD: begin
        if (keyPadInput == 4'b1111) begin
`ifdef KEYPAD_REPEAT_EN
          w_rep_nxt = '0;
`endif
          if (r_cnt == c_REL_LAST) begin
            w_held_nxt  = 1'b0;
            w_col_nxt   = r_col + 2'd1;
            w_slot_nxt  = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_SCAN;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_cnt_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
          if (r_rep == c_REP_LAST) begin
            w_valid_nxt = 1'b1;
            w_rep_nxt   = '0;
          end else begin
            w_rep_nxt = r_rep + CW'(1);
          end
`endif
        end
      end
      default: begin
        w_state_nxt = S_SCAN;
        w_slot_nxt  = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_SCAN;
      r_col       <= 2'd0;
      r_drv       <= 4'b0111;
      r_slot      <= '0;
      r_cnt       <= '0;
      r_cand_row  <= 2'd0;
      r_cand_pat  <= 4'b1111;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep       <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_drv       <= col_drive(w_col_nxt);
      r_slot      <= w_slot_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cand_row  <= w_cand_row_nxt;
      r_cand_pat  <= w_cand_pat_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
`ifdef KEYPAD_REPEAT_EN
      r_rep       <= w_rep_nxt;
`endif
    end
  end

  assign keyPadOutput = r_drv;
  assign keyCode      = r_key_code;
  assign keyValid     = r_key_valid;
  assign keyHeld      = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Purpose  : Scoreboard bench for keypad_scan_ctrl with a reactive keypad model.
//            Repeat scenario is included when KEYPAD_REPEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] code;
  logic       valid;
  logic       held;

  logic       k_down;
  logic [3:0] k_colpat;
  logic [3:0] k_rowpat;

  int         checks;
  int         failures;
  logic [3:0] exp_q[$];

  keypad_scan_ctrl #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CYC(8),
    .REPEAT_CYC  (16)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .keyPadInput (rows),
    .keyPadOutput(cols),
    .keyCode     (code),
    .keyValid    (valid),
    .keyHeld     (held)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // A pressed key pulls its row pattern low only while its column is driven.
  assign rows = (k_down && (cols == k_colpat)) ? k_rowpat : 4'b1111;

  function automatic logic [3:0] colpat(input int c);
    logic [3:0] one;
    one = 4'b1000;
    return ~(one >> c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic monitor();
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (!reset && valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe actual=%0d required=none", code);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_code", 32'(code), 32'(e));
        end
      end
    end
  endtask

  task automatic set_key(input int c, input logic [3:0] rp);
    k_colpat = colpat(c);
    k_rowpat = rp;
  endtask

  task automatic wait_col0_start();
    logic [3:0] prev;
    bit ok;
    ok   = 1'b0;
    prev = cols;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cols == 4'b0111 && prev != 4'b0111) begin
        ok = 1'b1;
        break;
      end
      prev = cols;
    end
    if (!ok) chk("col0_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_held(input logic v, input string name);
    for (int i = 0; i < 200; i++) begin
      if (held == v) break;
      @(negedge clk);
    end
    chk(name, 32'(held), 32'(v));
  endtask

  task automatic release_measure(input int req_n, input string name);
    int n;
    n      = 0;
    k_down = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (!held) break;
    end
    chk(name, 32'(n), 32'(req_n));
  endtask

  task automatic press_release(input int c, input logic [3:0] rp, input logic [3:0] ec);
    set_key(c, rp);
    exp_q.push_back(ec);
    k_down = 1'b1;
    wait_held(1'b1, "press_held");
    repeat (5) @(negedge clk);
    chk("column_frozen", 32'(cols), 32'(colpat(c)));
    release_measure(8, "release_cycles");
    chk("next_column", 32'(cols), 32'(colpat((c + 1) % 4)));
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int n;
    int trans;
    logic [3:0] prev;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    k_down   = 1'b0;
    k_colpat = 4'b0111;
    k_rowpat = 4'b1111;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_cols",  32'(cols),  32'(4'b0111));
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_held",  32'(held),  32'd0);
    chk("reset_code",  32'(code),  32'd0);

    // Idle scan: four cycles per column, wrapping.
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      chk("scan_sequence", 32'(cols), 32'(colpat((k / 4) % 4)));
    end

    press_release(0, 4'b0111, 4'd0);
    press_release(0, 4'b1110, 4'd3);
    press_release(0, 4'b1011, 4'd1);
    press_release(3, 4'b1101, 4'd14);

    // Bounce aligned to the sample slot of column 0.
    set_key(0, 4'b0111);
    wait_col0_start();
    repeat (3) @(negedge clk);
    k_down = 1'b1;
    repeat (3) @(negedge clk);
    k_down = 1'b0;
    @(negedge clk);
    chk("bounce_no_held", 32'(held), 32'd0);
    exp_q.push_back(4'd0);
    k_down = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (valid) break;
    end
    chk("bounce_latency", 32'(n), 32'd12);
    release_measure(8, "bounce_release_cycles");
    repeat (6) @(negedge clk);

    // Release glitch restarts the release count.
    set_key(0, 4'b0111);
    exp_q.push_back(4'd0);
    k_down = 1'b1;
    wait_held(1'b1, "glitch_press_held");
    k_down = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_still_held", 32'(held), 32'd1);
    k_down = 1'b1;
    @(negedge clk);
    release_measure(8, "glitch_release_cycles");
    chk("glitch_next_column", 32'(cols), 32'(4'b1011));
    repeat (6) @(negedge clk);

    // Two rows low is never accepted; scanning keeps moving.
    set_key(0, 4'b0011);
    k_down = 1'b1;
    trans  = 0;
    prev   = cols;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cols != prev) trans++;
      prev = cols;
    end
    chk("multirow_transitions", 32'(trans), 32'd10);
    chk("multirow_no_held", 32'(held), 32'd0);
    k_down = 1'b0;

    // Reset during debounce drops the press.
    set_key(0, 4'b0111);
    wait_col0_start();
    repeat (3) @(negedge clk);
    k_down = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_cols",  32'(cols),  32'(4'b0111));
    chk("midreset_valid", 32'(valid), 32'd0);
    chk("midreset_held",  32'(held),  32'd0);
    k_down = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midreset_idle_held", 32'(held), 32'd0);

    // A key held through reset strobes again after reset.
    set_key(2, 4'b1011);
    exp_q.push_back(4'd9);
    k_down = 1'b1;
    wait_held(1'b1, "prereset_held");
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(4'd9);
    @(negedge clk);
    reset = 1'b0;
    wait_held(1'b1, "postreset_held");
    chk("postreset_code", 32'(code), 32'd9);
    release_measure(8, "postreset_release_cycles");
    repeat (6) @(negedge clk);

`ifdef KEYPAD_REPEAT_EN
    set_key(0, 4'b1011);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd1);
    k_down = 1'b1;
    wait_held(1'b1, "repeat_held");
    repeat (60) @(negedge clk);
    release_measure(8, "repeat_release_cycles");
    repeat (6) @(negedge clk);
`endif

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
